// File: rtl/philv_tb_pkg.sv
// Shared definitions for the register-file compare engine: FSM encoding and
// default sizing.
package philv_tb_pkg;

  localparam int DEF_XLEN       = 32;
  localparam int DEF_NUM_REGS   = 32;
  localparam int DEF_RUN_CYCLES = 1000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_CMP   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/rf_cmp_counter.sv
// Up-counter from 0 to MAX-1 with a terminal flag; wraps to 0 when advanced
// past the terminal value.
module rf_cmp_counter #(
  parameter int WIDTH = 8,
  parameter int MAX   = 256
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             term
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MAX - 1);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  assign term  = (cnt_q == LAST);
  assign count = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = term ? '0 : cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/rf_compare_engine.sv
// Register-file compare engine: runs the core for a fixed time, then reads every
// register and compares it with an expected-value store, reporting errors.
module rf_compare_engine
  import philv_tb_pkg::*;
#(
  parameter int  XLEN          = DEF_XLEN,
  parameter int  NUM_REGS      = DEF_NUM_REGS,
  parameter int  RUN_CYCLES    = DEF_RUN_CYCLES,
  parameter bit  STOP_ON_FIRST = 1'b0,
  localparam int IDX_W         = $clog2(NUM_REGS)
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             start,
  output logic             run_en,
  output logic [IDX_W-1:0] rf_raddr,
  input  logic [XLEN-1:0]  rf_rdata,
  output logic [IDX_W-1:0] exp_raddr,
  input  logic [XLEN-1:0]  exp_rdata,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [IDX_W:0]   err_count,
  output logic [IDX_W-1:0] first_err_idx,
  output logic             first_err_vld
);

  localparam int             RUN_W   = (RUN_CYCLES > 1) ? $clog2(RUN_CYCLES) : 1;
  localparam logic [IDX_W:0] ERR_MAX = (IDX_W + 1)'(NUM_REGS);

  function automatic logic [IDX_W:0] sat_inc(input logic [IDX_W:0] v);
    if (v >= ERR_MAX) begin
      return v;
    end
    return v + (IDX_W + 1)'(1);
  endfunction

  state_t           state_q, state_d;
  logic             issue_end_q, issue_end_d;
  logic             rd_vld_p1_q, rd_vld_p1_d;
  logic [IDX_W-1:0] rd_idx_p1_q, rd_idx_p1_d;
  logic [IDX_W:0]   err_count_q, err_count_d;
  logic [IDX_W-1:0] first_err_idx_q, first_err_idx_d;
  logic             first_err_vld_q, first_err_vld_d;
  logic             done_q, done_d;

  logic             start_run;
  logic             issuing;
  logic             mismatch;
  logic             run_term;
  logic [RUN_W-1:0] run_cnt_unused;
  logic [IDX_W-1:0] idx_cnt;
  logic             idx_term;

  rf_cmp_counter #(.WIDTH(RUN_W), .MAX(RUN_CYCLES)) u_run_cnt (
    .clk   (clk),
    .rstb  (rstb),
    .clr   (start_run),
    .en    (run_en),
    .count (run_cnt_unused),
    .term  (run_term)
  );

  rf_cmp_counter #(.WIDTH(IDX_W), .MAX(NUM_REGS)) u_idx_cnt (
    .clk   (clk),
    .rstb  (rstb),
    .clr   (start_run),
    .en    (issuing),
    .count (idx_cnt),
    .term  (idx_term)
  );

  assign run_en        = (state_q == ST_RUN);
  assign busy          = (state_q == ST_RUN) || (state_q == ST_CMP) || (state_q == ST_DRAIN);
  assign issuing       = (state_q == ST_CMP) && !issue_end_q;
  assign rf_raddr      = issuing ? idx_cnt : '0;
  assign exp_raddr     = rf_raddr;
  assign done          = done_q;
  assign pass          = (state_q == ST_DONE) && (err_count_q == '0);
  assign err_count     = err_count_q;
  assign first_err_idx = first_err_idx_q;
  assign first_err_vld = first_err_vld_q;

  always_comb begin
    state_d         = state_q;
    issue_end_d     = issue_end_q;
    err_count_d     = err_count_q;
    first_err_idx_d = first_err_idx_q;
    first_err_vld_d = first_err_vld_q;
    start_run       = 1'b0;
    rd_vld_p1_d     = issuing;
    rd_idx_p1_d     = idx_cnt;
    // p1: data returned for the index issued last cycle is compared here
    mismatch        = (state_q == ST_CMP) && rd_vld_p1_q && (rf_rdata != exp_rdata);

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          start_run       = 1'b1;
          state_d         = ST_RUN;
          issue_end_d     = 1'b0;
          err_count_d     = '0;
          first_err_idx_d = '0;
          first_err_vld_d = 1'b0;
        end
      end
      ST_RUN: begin
        if (run_term) begin
          state_d = ST_CMP;
        end
      end
      ST_CMP: begin
        if (issuing && idx_term) begin
          issue_end_d = 1'b1;
        end
        if (mismatch) begin
          err_count_d = sat_inc(err_count_q);
          if (!first_err_vld_q) begin
            first_err_idx_d = rd_idx_p1_q;
            first_err_vld_d = 1'b1;
          end
        end
        // Early stop leaves the read issued this cycle to die in DRAIN.
        if ((mismatch && STOP_ON_FIRST) || (issue_end_q && rd_vld_p1_q)) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    done_d = (state_d == ST_DONE) && (state_q != ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      state_q         <= ST_IDLE;
      issue_end_q     <= 1'b0;
      rd_vld_p1_q     <= 1'b0;
      err_count_q     <= '0;
      first_err_idx_q <= '0;
      first_err_vld_q <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      issue_end_q     <= issue_end_d;
      rd_vld_p1_q     <= rd_vld_p1_d;
      err_count_q     <= err_count_d;
      first_err_idx_q <= first_err_idx_d;
      first_err_vld_q <= first_err_vld_d;
      done_q          <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    rd_idx_p1_q <= rd_idx_p1_d;
  end

endmodule

// File: tb/tb_rf_compare_engine.sv
// Bench for rf_compare_engine: a full-compare and a stop-on-first instance share
// stimulus; results are checked against a register-array reference model.
module tb_rf_compare_engine;

  localparam int XLEN     = 32;
  localparam int NREG     = 32;
  localparam int RC       = 10;
  localparam int IW       = 5;
  localparam int FULL_LAT = RC + NREG + 2;
  localparam int WIN      = FULL_LAT + 2;

  logic clk = 1'b0;
  logic rstb = 1'b0;
  logic start = 1'b0;

  logic            run_en_a, busy_a, done_a, pass_a, first_err_vld_a;
  logic [IW-1:0]   rf_raddr_a, exp_raddr_a, first_err_idx_a;
  logic [IW:0]     err_count_a;
  logic [XLEN-1:0] rf_rdata_a, exp_rdata_a;

  logic            run_en_b, busy_b, done_b, pass_b, first_err_vld_b;
  logic [IW-1:0]   rf_raddr_b, exp_raddr_b, first_err_idx_b;
  logic [IW:0]     err_count_b;
  logic [XLEN-1:0] rf_rdata_b, exp_rdata_b;

  logic [XLEN-1:0] rf_mem  [NREG];
  logic [XLEN-1:0] exp_mem [NREG];

  int checks = 0;
  int fails  = 0;
  int lat_a, lat_b, run_a, dp_a, dp_b, addr_err, err0_a;

  rf_compare_engine #(.XLEN(XLEN), .NUM_REGS(NREG), .RUN_CYCLES(RC), .STOP_ON_FIRST(1'b0)) dut_a (
    .clk(clk), .rstb(rstb), .start(start), .run_en(run_en_a),
    .rf_raddr(rf_raddr_a), .rf_rdata(rf_rdata_a),
    .exp_raddr(exp_raddr_a), .exp_rdata(exp_rdata_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_count_a),
    .first_err_idx(first_err_idx_a), .first_err_vld(first_err_vld_a)
  );

  rf_compare_engine #(.XLEN(XLEN), .NUM_REGS(NREG), .RUN_CYCLES(RC), .STOP_ON_FIRST(1'b1)) dut_b (
    .clk(clk), .rstb(rstb), .start(start), .run_en(run_en_b),
    .rf_raddr(rf_raddr_b), .rf_rdata(rf_rdata_b),
    .exp_raddr(exp_raddr_b), .exp_rdata(exp_rdata_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_count_b),
    .first_err_idx(first_err_idx_b), .first_err_vld(first_err_vld_b)
  );

  always #5 clk = ~clk;

  // Synchronous-read storage: data appears one cycle after the address.
  always @(posedge clk) begin
    rf_rdata_a  <= rf_mem[rf_raddr_a];
    exp_rdata_a <= exp_mem[exp_raddr_a];
    rf_rdata_b  <= rf_mem[rf_raddr_b];
    exp_rdata_b <= exp_mem[exp_raddr_b];
  end

  task automatic fill_equal();
    for (int i = 0; i < NREG; i++) begin
      rf_mem[i]  = $urandom;
      exp_mem[i] = rf_mem[i];
    end
  endtask

  task automatic corrupt(input int idx);
    logic [XLEN-1:0] f;
    f = $urandom;
    if (f == '0) f = 1;
    exp_mem[idx] = rf_mem[idx] ^ f;
  endtask

  function automatic void model(output int cnt, output int first);
    cnt   = 0;
    first = -1;
    for (int i = 0; i < NREG; i++) begin
      if (rf_mem[i] != exp_mem[i]) begin
        cnt++;
        if (first < 0) first = i;
      end
    end
  endfunction

  // Start both engines and observe a fixed window; k=0 is the start-sampling edge.
  task automatic run_once(input int pulse_k);
    int ea;
    lat_a = -1; lat_b = -1; run_a = 0; dp_a = 0; dp_b = 0; addr_err = 0; err0_a = -1;
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    for (int k = 0; k <= WIN; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
      end
      if (k == 0) err0_a = int'(err_count_a);
      start = (k == pulse_k);
      if (run_en_a) run_a++;
      if (done_a) begin dp_a++; if (lat_a < 0) lat_a = k; end
      if (done_b) begin dp_b++; if (lat_b < 0) lat_b = k; end
      ea = (k >= RC && k < RC + NREG) ? k - RC : 0;
      if (int'(rf_raddr_a) != ea || rf_raddr_a !== exp_raddr_a || rf_raddr_b !== exp_raddr_b)
        addr_err++;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    fill_equal();
    rstb = 1'b0; start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if ({run_en_a, busy_a, done_a, pass_a, err_count_a, first_err_idx_a, first_err_vld_a, rf_raddr_a} !== '0) begin
      fails++; $display("FAIL reset_outputs_a: got busy=%0d run_en=%0d err=%0d expected all zero", busy_a, run_en_a, err_count_a);
    end
    checks++; if ({run_en_b, busy_b, done_b, pass_b, err_count_b, first_err_idx_b, first_err_vld_b, rf_raddr_b} !== '0) begin
      fails++; $display("FAIL reset_outputs_b: got busy=%0d run_en=%0d err=%0d expected all zero", busy_b, run_en_b, err_count_b);
    end
    start = 1'b0; rstb = 1'b1;
    @(posedge clk); #1;
    checks++; if (busy_a !== 1'b0) begin
      fails++; $display("FAIL reset_start_ignored: got busy=%0d expected 0", busy_a);
    end
  endtask

  task automatic test_all_match();
    fill_equal();
    run_once(-1);
    checks++; if (lat_a != FULL_LAT) begin fails++; $display("FAIL match_latency_a: got %0d expected %0d", lat_a, FULL_LAT); end
    checks++; if (lat_b != FULL_LAT) begin fails++; $display("FAIL match_latency_b: got %0d expected %0d", lat_b, FULL_LAT); end
    checks++; if (pass_a !== 1'b1) begin fails++; $display("FAIL match_pass: got %0d expected 1", pass_a); end
    checks++; if (err_count_a !== '0) begin fails++; $display("FAIL match_err: got %0d expected 0", err_count_a); end
    checks++; if (first_err_vld_a !== 1'b0) begin fails++; $display("FAIL match_vld: got %0d expected 0", first_err_vld_a); end
    checks++; if (run_a != RC) begin fails++; $display("FAIL match_run_cycles: got %0d expected %0d", run_a, RC); end
    checks++; if (addr_err != 0) begin fails++; $display("FAIL match_addr_seq: got %0d bad cycles expected 0", addr_err); end
    checks++; if (dp_a != 1 || dp_b != 1) begin fails++; $display("FAIL match_done_pulse: got %0d/%0d expected 1/1", dp_a, dp_b); end
    checks++; if (busy_a !== 1'b0) begin fails++; $display("FAIL match_busy_done: got %0d expected 0", busy_a); end
  endtask

  task automatic test_two_mismatch();
    fill_equal();
    corrupt(10);
    corrupt(31);
    run_once(-1);
    checks++; if (err_count_a !== 6'd2) begin fails++; $display("FAIL two_err_a: got %0d expected 2", err_count_a); end
    checks++; if (first_err_idx_a !== 5'd10 || first_err_vld_a !== 1'b1) begin
      fails++; $display("FAIL two_first_a: got idx=%0d vld=%0d expected 10/1", first_err_idx_a, first_err_vld_a);
    end
    checks++; if (pass_a !== 1'b0) begin fails++; $display("FAIL two_pass_a: got %0d expected 0", pass_a); end
    checks++; if (err_count_b !== 6'd1 || first_err_idx_b !== 5'd10) begin
      fails++; $display("FAIL two_stop_b: got err=%0d idx=%0d expected 1/10", err_count_b, first_err_idx_b);
    end
    checks++; if (lat_a - lat_b != 21) begin fails++; $display("FAIL two_stop_early: got %0d cycles earlier expected 21", lat_a - lat_b); end
    checks++; if (lat_a != FULL_LAT) begin fails++; $display("FAIL two_latency_a: got %0d expected %0d", lat_a, FULL_LAT); end
  endtask

  task automatic test_all_mismatch();
    fill_equal();
    for (int i = 0; i < NREG; i++) corrupt(i);
    run_once(-1);
    checks++; if (err_count_a !== 6'd32) begin fails++; $display("FAIL all_err_a: got %0d expected 32", err_count_a); end
    checks++; if (first_err_idx_a !== 5'd0 || first_err_vld_a !== 1'b1) begin
      fails++; $display("FAIL all_first_a: got idx=%0d vld=%0d expected 0/1", first_err_idx_a, first_err_vld_a);
    end
    checks++; if (err_count_b !== 6'd1 || lat_b != RC + 3) begin
      fails++; $display("FAIL all_stop_b: got err=%0d lat=%0d expected 1/%0d", err_count_b, lat_b, RC + 3);
    end
  endtask

  task automatic test_back_to_back();
    fill_equal();
    corrupt(5);
    run_once(-1);
    checks++; if (err0_a != 0) begin fails++; $display("FAIL b2b_cleared: got %0d expected 0", err0_a); end
    checks++; if (err_count_a !== 6'd1 || first_err_idx_a !== 5'd5) begin
      fails++; $display("FAIL b2b_result: got err=%0d idx=%0d expected 1/5", err_count_a, first_err_idx_a);
    end
    checks++; if (run_a != RC || lat_a != FULL_LAT) begin
      fails++; $display("FAIL b2b_timing: got run=%0d lat=%0d expected %0d/%0d", run_a, lat_a, RC, FULL_LAT);
    end
  endtask

  task automatic test_start_during_cmp();
    fill_equal();
    corrupt(20);
    run_once(RC + 5);
    checks++; if (lat_a != FULL_LAT || run_a != RC || dp_a != 1) begin
      fails++; $display("FAIL cmp_start_ignored: got lat=%0d run=%0d pulses=%0d expected %0d/%0d/1", lat_a, run_a, dp_a, FULL_LAT, RC);
    end
    checks++; if (err_count_a !== 6'd1 || first_err_idx_a !== 5'd20) begin
      fails++; $display("FAIL cmp_start_result: got err=%0d idx=%0d expected 1/20", err_count_a, first_err_idx_a);
    end
  endtask

  task automatic test_random();
    int cnt, first, elat_b, efirst;
    for (int it = 0; it < 8; it++) begin
      fill_equal();
      if (it % 4 != 0) begin
        for (int i = 0; i < NREG; i++) if ($urandom_range(7) == 0) corrupt(i);
      end
      model(cnt, first);
      efirst = (cnt > 0) ? first : 0;
      elat_b = (cnt > 0) ? RC + first + 3 : FULL_LAT;
      run_once(-1);
      checks++; if (int'(err_count_a) != cnt || int'(first_err_idx_a) != efirst || first_err_vld_a !== (cnt > 0)) begin
        fails++; $display("FAIL rand_full it%0d: got err=%0d idx=%0d vld=%0d expected %0d/%0d/%0d",
                          it, err_count_a, first_err_idx_a, first_err_vld_a, cnt, efirst, cnt > 0);
      end
      checks++; if (pass_a !== (cnt == 0) || lat_a != FULL_LAT) begin
        fails++; $display("FAIL rand_pass it%0d: got pass=%0d lat=%0d expected %0d/%0d", it, pass_a, lat_a, cnt == 0, FULL_LAT);
      end
      checks++; if (int'(err_count_b) != ((cnt > 0) ? 1 : 0) || int'(first_err_idx_b) != efirst || lat_b != elat_b) begin
        fails++; $display("FAIL rand_stop it%0d: got err=%0d idx=%0d lat=%0d expected %0d/%0d/%0d",
                          it, err_count_b, first_err_idx_b, lat_b, (cnt > 0) ? 1 : 0, efirst, elat_b);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    fill_equal();
    corrupt(3);
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
    end
    checks++; if (run_en_a !== 1'b1) begin fails++; $display("FAIL midrun_running: got run_en=%0d expected 1", run_en_a); end
    rstb = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    checks++; if ({run_en_a, busy_a, done_a, pass_a, err_count_a, first_err_idx_a, first_err_vld_a, rf_raddr_a} !== '0
                  || busy_b !== 1'b0) begin
      fails++; $display("FAIL midrun_reset: got run_en=%0d busy=%0d/%0d expected all zero", run_en_a, busy_a, busy_b);
    end
    start = 1'b0;
    @(posedge clk); #1; rstb = 1'b1;
    @(posedge clk); #1;
    checks++; if (busy_a !== 1'b0) begin fails++; $display("FAIL midrun_idle: got busy=%0d expected 0", busy_a); end
    fill_equal();
    run_once(-1);
    checks++; if (lat_a != FULL_LAT || pass_a !== 1'b1 || run_a != RC) begin
      fails++; $display("FAIL midrun_fresh: got lat=%0d pass=%0d run=%0d expected %0d/1/%0d", lat_a, pass_a, run_a, FULL_LAT, RC);
    end
  endtask

  initial begin
    test_reset();
    test_all_match();
    test_two_mismatch();
    test_all_mismatch();
    test_back_to_back();
    test_start_during_cmp();
    test_random();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/rf_compare_engine.md
RF_COMPARE_ENGINE -- requirements
Module: rf_compare_engine

Interface
REQ-001 SHALL have parameter XLEN, default 32, register data width.
REQ-002 SHALL have parameter NUM_REGS, default 32, registers compared (2..256).
REQ-003 SHALL have parameter RUN_CYCLES, default 1000, core run length in clk cycles (>=1).
REQ-004 SHALL have parameter STOP_ON_FIRST, default 0, 1 = end compare at first mismatch.
REQ-005 SHALL have derived localparam IDX_W = clog2(NUM_REGS).
REQ-006 SHALL have port clk  in  1  sole clock, rising edge.
REQ-007 SHALL have port rstb  in  1  reset, synchronous, active-low.
REQ-008 SHALL have port start  in  1  begin run+compare; sampled only in IDLE.
REQ-009 SHALL have port run_en  out  1  core run enable.
REQ-010 SHALL have port rf_raddr  out  IDX_W  register-file read index.
REQ-011 SHALL have port rf_rdata  in  XLEN  register-file data, valid 1 cycle after rf_raddr.
REQ-012 SHALL have port exp_raddr  out  IDX_W  expected-value store index, always equal to rf_raddr.
REQ-013 SHALL have port exp_rdata  in  XLEN  expected data, valid 1 cycle after exp_raddr.
REQ-014 SHALL have port busy  out  1  high in any state except IDLE/DONE.
REQ-015 SHALL have port done  out  1  one-cycle pulse on DONE entry.
REQ-016 SHALL have port pass  out  1  err_count == 0, valid from done.
REQ-017 SHALL have port err_count  out  IDX_W+1  mismatching registers.
REQ-018 SHALL have port first_err_idx  out  IDX_W  lowest mismatching index.
REQ-019 SHALL have port first_err_vld  out  1  first_err_idx valid.

Function
REQ-020 SHALL implement FSM states IDLE, RUN, CMP, DRAIN, DONE.
REQ-021 IDLE->RUN SHALL occur on start=1; results cleared on same edge.
REQ-022 RUN SHALL hold run_en=1 for exactly RUN_CYCLES cycles, then ->CMP; run_en=0 in all other states.
REQ-023 CMP SHALL issue rf_raddr 0,1,..,NUM_REGS-1, one per cycle, then ->DRAIN.
REQ-024 Compare SHALL occur one cycle after each issue: rf_rdata != exp_rdata (all XLEN bits) is a mismatch.
REQ-025 Each mismatch SHALL increment err_count by 1; max value NUM_REGS, no wrap.
REQ-026 First mismatch SHALL latch first_err_idx and set first_err_vld; later mismatches SHALL not change them.
REQ-027 STOP_ON_FIRST=1: on first mismatch, issue SHALL stop and FSM ->DRAIN; the in-flight read is discarded.
REQ-028 DRAIN SHALL last 1 cycle, then ->DONE.
REQ-029 Latency: done SHALL assert exactly RUN_CYCLES+NUM_REGS+2 cycles after the start-sampling edge (full compare).
REQ-030 DONE SHALL hold results; start in DONE SHALL behave as in IDLE (restart).
REQ-031 start while busy SHALL be ignored.
REQ-032 rf_raddr SHALL hold 0 outside CMP.

Reset
REQ-033 rstb=0 at a clk edge SHALL force IDLE from any state, including mid-RUN/CMP.
REQ-034 Reset values: run_en=0, busy=0, done=0, pass=0, err_count=0, first_err_idx=0, first_err_vld=0, rf_raddr=0, counters=0.
REQ-035 start SHALL be ignored in the cycle rstb=0.

Structure
REQ-036 State encoding and defaults (XLEN, NUM_REGS, RUN_CYCLES) SHALL live in shared package philv_tb_pkg.
REQ-037 Sub-module rf_cmp_counter (parametrised up-counter with terminal flag) SHALL be used for run and index counters.
REQ-038 Design SHALL be synthesizable; no delays or system tasks.

Verification
REQ-039 NUM_REGS=32, RUN_CYCLES=10, exp==rf everywhere, start -> done at cycle 44, pass=1, err_count=0, first_err_vld=0.
REQ-040 Mismatch at idx 10 and 31 only, STOP_ON_FIRST=0 -> err_count=2, first_err_idx=10, pass=0.
REQ-041 Same, STOP_ON_FIRST=1 -> err_count=1, first_err_idx=10, done 21 cycles earlier than full.
REQ-042 All 32 mismatch -> err_count=32 (no wrap), first_err_idx=0.
REQ-043 rstb=0 at RUN cycle 5 -> IDLE next edge, run_en=0, all outputs reset; fresh start completes normally.
REQ-044 start pulsed during CMP -> ignored; start in DONE -> new run, results cleared, run_en count exactly 10.
